// File: rtl/program_loader.sv
// program_loader: byte-stream program loader and CPU run sequencer.
// Takes a header byte N (word count, 0 = 2**ADDR_W) and N big-endian 16-bit words.
// It writes each word to instruction memory, pulses the CPU reset, runs the CPU
// until the loop flag is seen, and then reports done.
// Optional build macro: LOADER_WATCHDOG_EN. It adds a run-cycle watchdog that
// leaves RUN after WDT_MAX cycles and raises o_timeout while in DONE.
//
// state   | meaning
// IDLE    | waiting for a header byte (word count)
// LOAD_HI | waiting for the high byte of the next word
// LOAD_LO | waiting for the low byte of the next word
// WRITE   | one-cycle instruction memory write strobe
// CPU_RST | one-cycle CPU reset pulse
// RUN     | CPU enabled until loop flag (or watchdog expiry)
// DONE    | program finished; a new header restarts loading

module program_loader #(
  parameter int               ADDR_W  = 8,
  parameter int               INSTR_W = 16,
  parameter int               WDT_W   = 16,
  parameter logic [WDT_W-1:0] WDT_MAX = 16'hFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_byte,
  input  logic               i_byte_valid,
  output logic               o_byte_ready,
  input  logic               i_abort,
  input  logic               i_loopf,
  output logic [ADDR_W-1:0]  o_instr_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_we,
  output logic               o_cpu_rst,
  output logic               o_ON,
  output logic               o_control_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    CPU_RST = 3'd4,
    RUN     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    instr_addr_q, instr_addr_d;
  logic [ADDR_W-1:0]    word_idx_q, word_idx_d;
  logic [ADDR_W:0]      words_left_q, words_left_d;

  logic                 accept;
  logic                 last_word;
  logic                 wdt_tc;
  logic [ADDR_W:0]      hdr_words;

  // A byte is consumed only when ready and valid meet and no abort is pending
  assign accept    = i_byte_valid && o_byte_ready && !i_abort;
  // Word count is a down-counter; the write that sees 1 left is the last one
  assign last_word = (words_left_q == (ADDR_W+1)'(1));

  // Header 0 means a full memory image of 2**ADDR_W words
  always_comb begin
    hdr_words = (ADDR_W+1)'(i_byte);
    if (i_byte == 8'h00) begin
      hdr_words = {1'b1, {ADDR_W{1'b0}}};
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = LOAD_HI;
        LOAD_HI: if (accept) state_d = LOAD_LO;
        LOAD_LO: if (accept) state_d = WRITE;
        WRITE:   state_d = last_word ? CPU_RST : LOAD_HI;
        CPU_RST: state_d = RUN;
        RUN: begin
          if (i_loopf)     state_d = DONE;
          else if (wdt_tc) state_d = DONE;
        end
        DONE:    if (accept) state_d = LOAD_HI;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state. DONE also accepts a new
  // header, so the loader is ready there as well.
  always_comb begin
    o_byte_ready = 1'b0;
    o_instr_we   = 1'b0;
    o_cpu_rst    = 1'b0;
    o_ON         = 1'b0;
    o_control_en = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (state_q)
      IDLE: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b0;
      end
      LOAD_HI, LOAD_LO: o_byte_ready = 1'b1;
      WRITE:   o_instr_we = 1'b1;
      CPU_RST: o_cpu_rst  = 1'b1;
      RUN: begin
        o_ON         = 1'b1;
        o_control_en = 1'b1;
      end
      DONE: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b0;
        o_done       = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  // Datapath next values: word assembly, write address and word bookkeeping
  always_comb begin
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    word_idx_d   = word_idx_q;
    words_left_d = words_left_q;
    if (i_abort) begin
      instr_d      = '0;
      instr_addr_d = '0;
      word_idx_d   = '0;
      words_left_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            words_left_d = hdr_words;
            word_idx_d   = '0;
          end
        end
        LOAD_HI: begin
          if (accept) instr_d[INSTR_W-1 -: 8] = i_byte;
        end
        LOAD_LO: begin
          if (accept) begin
            instr_d[7:0] = i_byte;
            instr_addr_d = word_idx_q;
          end
        end
        WRITE: begin
          word_idx_d   = word_idx_q + ADDR_W'(1);
          words_left_d = words_left_q - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; output address/data hold between writes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      instr_q      <= '0;
      instr_addr_q <= '0;
      word_idx_q   <= '0;
      words_left_q <= '0;
    end else begin
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      word_idx_q   <= word_idx_d;
      words_left_q <= words_left_d;
    end
  end

  assign o_instr      = instr_q;
  assign o_instr_addr = instr_addr_q;

`ifdef LOADER_WATCHDOG_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;

  // Watchdog counts down from WDT_MAX-1 loaded at RUN entry; reaching zero
  // in a RUN cycle means WDT_MAX run cycles elapsed. Loop flag takes priority.
  assign wdt_tc = (state_q == RUN) && (wdt_q == '0);

  // Watchdog and timeout flag next values
  always_comb begin
    wdt_d     = wdt_q;
    timeout_d = timeout_q;
    if (i_abort) begin
      wdt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        CPU_RST: wdt_d = WDT_MAX - WDT_W'(1);
        RUN: begin
          if (!i_loopf && wdt_tc) timeout_d = 1'b1;
          else if (wdt_q != '0)   wdt_d     = wdt_q - WDT_W'(1);
        end
        DONE: if (accept) timeout_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Watchdog and timeout flag registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_wdt_cfg;

  assign wdt_tc         = 1'b0;
  assign o_timeout      = 1'b0;
  assign unused_wdt_cfg = ^WDT_MAX;
`endif

endmodule
